// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin packet arbiter in front of a shared valid/ready channel.
//   One requester owns the channel from its first beat until its last beat
//   transfers; a one-cycle arbitration bubble separates every pair of packets.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   per-requester beat valid            [N_REQ]
//   in_data    per-requester data, requester i at  [i*DATA_W +: DATA_W]
//   in_last    per-requester end-of-packet         [N_REQ]
//   in_ready   per-requester accept (one-hot or 0) [N_REQ]
//   out_valid  shared-channel beat valid
//   out_data   shared-channel data
//   out_last   shared-channel end-of-packet
//   out_ready  downstream accept
//   grant_id   current owner, meaningful only while busy
//   busy       a packet owns the channel
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid requesters, nothing transfers
// OWN   | grant_id owns the channel until its last beat transfers
module rr_mux_arbiter #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          in_valid,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  input  logic [N_REQ-1:0]          in_last,
  output logic [N_REQ-1:0]          in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [1:0]                grant_id,
  output logic                      busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t     state, next_state;
  logic [1:0] last_grant, last_grant_next;
  logic [1:0] grant_next;
  logic [1:0] win_id;
  logic [1:0] cand;
  logic       win_found;

  // Cyclic search starting just after the previous owner; the offset of
  // N_REQ wraps back onto last_grant itself, so it is tried last.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_grant;
    cand      = last_grant;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last_grant + 2'(i);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      state      <= next_state;
      grant_id   <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    next_state      = state;
    grant_next      = grant_id;
    last_grant_next = last_grant;
    out_valid       = 1'b0;
    out_last        = 1'b0;
    out_data        = '0;
    in_ready        = '0;
    busy            = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          next_state = OWN;
          grant_next = win_id;
        end
      end
      OWN: begin
        busy               = 1'b1;
        out_valid          = in_valid[grant_id];
        out_last           = in_last[grant_id];
        out_data           = in_data[grant_id*DATA_W +: DATA_W];
        in_ready[grant_id] = out_ready;
        // Only the owner's final beat releases the channel.
        if (in_valid[grant_id] && out_ready && in_last[grant_id]) begin
          next_state      = IDLE;
          last_grant_next = grant_id;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int DATA_W = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [31:0]   in_data;
  logic [3:0]    in_last;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_ready;
  logic [1:0]    grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;

  rr_mux_arbiter #(.DATA_W(DATA_W), .N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [7:0] d, input logic l);
    in_valid[idx] = v;
    in_data[idx*8 +: 8] = d;
    in_last[idx] = l;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 4'b1111;
    in_data = 32'hDDCC_BBAA;
    in_last = 4'b1111;
    out_ready = 1'b1;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++;
    if ({out_valid, out_last, in_ready, out_data} !== 14'd0)
      begin errors++; $display("FAIL reset_outputs: got v=%b l=%b rdy=%b d=%h expected all 0", out_valid, out_last, in_ready, out_data); end
    in_valid = 4'b0000;
    in_last = 4'b0000;
    in_data = '0;
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold: got busy=%b expected 0", busy); end
  endtask

  task automatic test_single_beat();
    set_req(2, 1'b1, 8'hA5, 1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000)
      begin errors++; $display("FAIL bubble: got v=%b rdy=%b expected 0/0000", out_valid, in_ready); end
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd2)
      begin errors++; $display("FAIL single_grant: got busy=%b g=%0d expected 1/2", busy, grant_id); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b1 || in_ready !== 4'b0100)
      begin errors++; $display("FAIL single_chan: got v=%b d=%h l=%b rdy=%b expected 1/a5/1/0100", out_valid, out_data, out_last, in_ready); end
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b0 || out_data !== 8'h00)
      begin errors++; $display("FAIL single_done: got busy=%b d=%h expected 0/00", busy, out_data); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rot_idle%0d: got busy=%b expected 0", k, busy); end
      tick();
      checks++;
      if (busy !== 1'b1 || grant_id !== exp_g[k] || out_data !== 8'(8'h10 + exp_g[k]))
        begin errors++; $display("FAIL rot_grant%0d: got busy=%b g=%0d d=%h expected 1/%0d/%h", k, busy, grant_id, out_data, exp_g[k], 8'(8'h10 + exp_g[k])); end
      tick();
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_multibeat();
    logic [7:0] beats [3] = '{8'h11, 8'h22, 8'h33};
    set_req(0, 1'b1, 8'h0C, 1'b1);
    set_req(1, 1'b1, beats[0], 1'b0);
    #1;
    tick();
    for (int b = 0; b < 3; b++) begin
      set_req(1, 1'b1, beats[b], b == 2);
      #1;
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd1 || out_data !== beats[b] || out_last !== (b == 2) || in_ready !== 4'b0010)
        begin errors++; $display("FAIL mb_beat%0d: got g=%0d d=%h l=%b rdy=%b expected 1/%h/%0d/0010", b, grant_id, out_data, out_last, in_ready, beats[b], b == 2); end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mb_gap: got busy=%b expected 0", busy); end
    tick();
    checks++;
    if (grant_id !== 2'd0 || out_data !== 8'h0C)
      begin errors++; $display("FAIL mb_next: got g=%0d d=%h expected 0/0c", grant_id, out_data); end
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    #1;
  endtask

  task automatic test_backpressure();
    int start_cnt;
    start_cnt = xfer_cnt;
    set_req(3, 1'b1, 8'h31, 1'b0);
    #1;
    tick();
    checks++;
    if (grant_id !== 2'd3 || out_data !== 8'h31)
      begin errors++; $display("FAIL bp_grant: got g=%0d d=%h expected 3/31", grant_id, out_data); end
    tick();
    set_req(3, 1'b0, 8'h32, 1'b1);
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_drop: got busy=%b v=%b expected 1/0", busy, out_valid); end
    tick();
    set_req(3, 1'b1, 8'h32, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h32 || in_ready !== 4'b0000)
        begin errors++; $display("FAIL bp_stall%0d: got busy=%b v=%b d=%h rdy=%b expected 1/1/32/0000", c, busy, out_valid, out_data, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release: got rdy=%b expected 1000", in_ready); end
    tick();
    set_req(3, 1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b0 || xfer_cnt - start_cnt != 2)
      begin errors++; $display("FAIL bp_count: got busy=%b beats=%0d expected 0/2", busy, xfer_cnt - start_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 1'b1, 8'h05, 1'b1);
    #1;
    tick();
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h2A, 1'b0);
    #1;
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd2)
      begin errors++; $display("FAIL ar_own: got busy=%b g=%0d expected 1/2", busy, grant_id); end
    set_req(0, 1'b1, 8'h05, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || {out_valid, out_last, in_ready, out_data} !== 14'd0)
      begin errors++; $display("FAIL ar_async: got busy=%b g=%0d v=%b l=%b rdy=%b d=%h expected all 0", busy, grant_id, out_valid, out_last, in_ready, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || out_data !== 8'h05)
      begin errors++; $display("FAIL ar_regrant: got busy=%b g=%0d d=%h expected 1/0/05", busy, grant_id, out_data); end
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    in_valid = '0;
    in_data = '0;
    in_last = '0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    test_reset();
    test_single_beat();
    test_rotation();
    test_multibeat();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
